// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. Synchronises the serial line, de-frames
// LSB-first characters and hands each byte to a one-entry AXI-stream
// output register. Framing errors and overruns are flagged as 1-cycle pulses.
module uart_rx #(
   parameter int cycles_per_bit = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       tready,
   output logic       tvalid,
   output logic [7:0] tdata,
   output logic       frame_err,
   output logic       overflow
);

   localparam int CNT_W = $clog2(cycles_per_bit);
   // First sample lands mid start bit; later samples are one full bit apart.
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(cycles_per_bit / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(cycles_per_bit - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   logic [1:0]       r_sync;
   logic             w_rx_s;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_timer;
   logic [CNT_W-1:0] w_timer_nxt;
   logic [2:0]       r_bit_idx;
   logic [2:0]       w_bit_idx_nxt;
   logic [7:0]       r_shift;
   logic [7:0]       w_shift_nxt;
   logic             w_commit;
   logic             w_frame_err;
   logic             r_tvalid;
   logic [7:0]       r_tdata;
   logic             r_frame_err;
   logic             r_overflow;

   // Two-flop synchroniser; resets to the idle (high) line level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], rx};
      end
   end

   assign w_rx_s = r_sync[1];

   // Receiver state, bit timer, bit index and shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_timer   <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_timer   <= w_timer_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
      end
   end

   // Frame sequencing: every decision is taken when the timer expires.
   always_comb begin
      w_state_nxt   = r_state;
      w_timer_nxt   = r_timer;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_commit      = 1'b0;
      w_frame_err   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_rx_s) begin
               w_state_nxt = S_START;
               w_timer_nxt = HALF_LOAD;
            end
         end
         S_START: begin
            if (r_timer != '0) begin
               w_timer_nxt = r_timer - 1'b1;
            end else if (w_rx_s) begin
               // Line back high at mid start bit: a glitch, not a character.
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt   = S_DATA;
               w_timer_nxt   = FULL_LOAD;
               w_bit_idx_nxt = '0;
            end
         end
         S_DATA: begin
            if (r_timer != '0) begin
               w_timer_nxt = r_timer - 1'b1;
            end else begin
               w_shift_nxt[r_bit_idx] = w_rx_s;
               w_timer_nxt            = FULL_LOAD;
               w_bit_idx_nxt          = r_bit_idx + 3'd1;
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (r_timer != '0) begin
               w_timer_nxt = r_timer - 1'b1;
            end else if (w_rx_s) begin
               // Leave at mid stop bit so a back-to-back start edge is seen.
               w_commit    = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_frame_err = 1'b1;
               w_state_nxt = S_BREAK;
            end
         end
         S_BREAK: begin
            if (w_rx_s) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // One-entry output register with AXI-stream handshake and overrun pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tvalid    <= 1'b0;
         r_tdata     <= '0;
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_frame_err <= w_frame_err;
         r_overflow  <= 1'b0;
         if (w_commit) begin
            if (!r_tvalid || tready) begin
               r_tdata  <= r_shift;
               r_tvalid <= 1'b1;
            end else begin
               r_overflow <= 1'b1;
            end
         end else if (r_tvalid && tready) begin
            r_tvalid <= 1'b0;
         end
      end
   end

   assign tvalid    = r_tvalid;
   assign tdata     = r_tdata;
   assign frame_err = r_frame_err;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames onto rx and checks the receiver against a
// byte-level model of the line and of a single-slot output buffer.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int  CPB  = 32;
   localparam int  H    = CPB / 2;
   localparam time TCLK = 20;
   // Outputs react 3 clocks after the mid-stop sample edge; checked at the falling edge.
   localparam time LAT  = 3 * TCLK + TCLK / 2;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       rx     = 1'b1;
   logic       tready = 1'b1;
   logic       tvalid;
   logic [7:0] tdata;
   logic       frame_err;
   logic       overflow;

   uart_rx #(.cycles_per_bit(CPB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .tready    (tready),
      .tvalid    (tvalid),
      .tdata     (tdata),
      .frame_err (frame_err),
      .overflow  (overflow)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      time        t;
   } ev_t;

   ev_t        exp_q[$];
   time        ferr_q[$];
   time        ovf_q[$];
   int         checks    = 0;
   int         failures  = 0;
   int         beats     = 0;
   int         ferr_seen = 0;
   int         ovf_seen  = 0;
   logic [7:0] last_byte = 8'h00;
   logic       prev_tvalid = 1'b0;
   logic       prev_tready = 1'b0;
   logic [7:0] prev_tdata  = 8'h00;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Advance n rising edges, then step 1 ns past the edge to drive inputs.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Byte-level model: called at the mid-stop sample edge of every frame.
   task automatic model_stop(input logic [7:0] b, input logic stop_ok);
      ev_t e;
      if (!stop_ok) begin
         ferr_q.push_back($time - 1);
      end else if (exp_q.size() != 0) begin
         ovf_q.push_back($time - 1);
      end else begin
         e.data = b;
         e.t    = $time - 1;
         exp_q.push_back(e);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = stop_bit;
      tick(H);
      model_stop(b, stop_bit);
      tick(CPB - H);
   endtask

   // Compare process: checks outputs against the model on every falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_tvalid", tvalid, 1'b0);
         chk("reset_tdata", tdata, 8'h00);
         chk("reset_frame_err", frame_err, 1'b0);
         chk("reset_overflow", overflow, 1'b0);
         prev_tvalid = 1'b0;
         prev_tready = 1'b0;
      end else begin
         if (prev_tvalid && !prev_tready) begin
            chk("axi_hold_tvalid", tvalid, 1'b1);
            chk("axi_hold_tdata", tdata, prev_tdata);
         end
         if (frame_err) begin
            ferr_seen++;
            if (ferr_q.size() == 0) chk("frame_err_unexpected", frame_err, 1'b0);
            else begin
               chk("frame_err_latency", $time - ferr_q[0], LAT);
               void'(ferr_q.pop_front());
            end
         end else if (ferr_q.size() != 0 && ($time - ferr_q[0]) > LAT) begin
            chk("frame_err_missing", frame_err, 1'b1);
            void'(ferr_q.pop_front());
         end
         if (overflow) begin
            ovf_seen++;
            if (ovf_q.size() == 0) chk("overflow_unexpected", overflow, 1'b0);
            else begin
               chk("overflow_latency", $time - ovf_q[0], LAT);
               void'(ovf_q.pop_front());
            end
         end else if (ovf_q.size() != 0 && ($time - ovf_q[0]) > LAT) begin
            chk("overflow_missing", overflow, 1'b1);
            void'(ovf_q.pop_front());
         end
         if (tvalid) begin
            if (exp_q.size() == 0) chk("tvalid_unexpected", tvalid, 1'b0);
            else begin
               chk("tdata", tdata, exp_q[0].data);
               if (!prev_tvalid) chk("tvalid_latency", $time - exp_q[0].t, LAT);
               if (tready) begin
                  beats++;
                  last_byte = tdata;
                  void'(exp_q.pop_front());
               end
            end
         end else if (exp_q.size() != 0 && ($time - exp_q[0].t) > LAT) begin
            chk("tvalid_late", tvalid, 1'b1);
            void'(exp_q.pop_front());
         end
         prev_tvalid = tvalid;
         prev_tready = tready;
         prev_tdata  = tdata;
      end
   end

   initial begin
      int         b0;
      int         f0;
      int         o0;
      int         gap;
      logic [7:0] rb;
      logic       sb;

      // Reset state
      tick(4);
      chk("por_tvalid", tvalid, 1'b0);
      chk("por_tdata", tdata, 8'h00);
      rst_n = 1'b1;
      tick(CPB);

      // Single frame 0x55
      b0 = beats; f0 = ferr_seen; o0 = ovf_seen;
      send_frame(8'h55, 1'b1);
      tick(CPB);
      chk("t1_beats", beats - b0, 1);
      chk("t1_byte", last_byte, 8'h55);
      chk("t1_errors", (ferr_seen - f0) + (ovf_seen - o0), 0);

      // Seven random bytes back-to-back
      b0 = beats;
      for (int i = 0; i < 7; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
      tick(CPB);
      chk("t2_beats", beats - b0, 7);

      // Short low glitch must be rejected
      b0 = beats; f0 = ferr_seen;
      rx = 1'b0;
      tick(H / 2);
      rx = 1'b1;
      tick(2 * CPB);
      chk("t3_beats", beats - b0, 0);
      chk("t3_ferr", ferr_seen - f0, 0);

      // Bad stop bit, then a good frame
      b0 = beats; f0 = ferr_seen;
      send_frame(8'hA3, 1'b0);
      tick(CPB / 2);
      rx = 1'b1;
      tick(CPB);
      chk("t4_ferr", ferr_seen - f0, 1);
      chk("t4_no_beat", beats - b0, 0);
      send_frame(8'h0F, 1'b1);
      tick(CPB);
      chk("t4_beats", beats - b0, 1);
      chk("t4_byte", last_byte, 8'h0F);

      // Overrun with tready low
      b0 = beats; o0 = ovf_seen;
      tready = 1'b0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      tick(CPB);
      chk("t5_tvalid_held", tvalid, 1'b1);
      chk("t5_tdata_held", tdata, 8'h11);
      chk("t5_overflow", ovf_seen - o0, 1);
      tready = 1'b1;
      tick(3);
      chk("t5_beats", beats - b0, 1);
      chk("t5_byte", last_byte, 8'h11);
      chk("t5_tvalid_clear", tvalid, 1'b0);

      // Reset during data bit 4 with a byte pending
      b0 = beats;
      tready = 1'b0;
      send_frame(8'h5A, 1'b1);
      tick(CPB);
      rb = 8'h96;
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = rb[i];
         tick(CPB);
      end
      rx = rb[4];
      tick(H);
      rst_n = 1'b0;
      exp_q.delete();
      ferr_q.delete();
      ovf_q.delete();
      rx = 1'b1;
      tick(3);
      chk("t6_tvalid_in_reset", tvalid, 1'b0);
      rst_n = 1'b1;
      tready = 1'b1;
      tick(CPB);
      chk("t6_tvalid_after", tvalid, 1'b0);
      send_frame(8'hC3, 1'b1);
      tick(CPB);
      chk("t6_beats", beats - b0, 1);
      chk("t6_byte", last_byte, 8'hC3);

      // Randomised traffic: data, stop errors, back-pressure and gaps
      for (int i = 0; i < 25; i++) begin
         rb = 8'($urandom_range(0, 255));
         sb = ($urandom_range(0, 4) != 0);
         tready = ($urandom_range(0, 9) < 7);
         tick(2);
         send_frame(rb, sb);
         if (!sb) begin
            gap = $urandom_range(0, 2 * CPB);
            if (gap > 0) tick(gap);
            rx = 1'b1;
            tick(CPB);
         end else begin
            gap = $urandom_range(0, CPB);
            if (gap > 0) tick(gap);
         end
      end
      tready = 1'b1;
      tick(2 * CPB);
      chk("end_pending_beats", exp_q.size(), 0);
      chk("end_pending_ferr", ferr_q.size(), 0);
      chk("end_pending_ovf", ovf_q.size(), 0);
      chk("end_tvalid", tvalid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
